parallel_to_serial: RTL and testbench

Transmit-side counterpart of the serial-to-parallel receiver. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial data line, with a frame-start marker on the first bit and a frame-end marker on the last. A one-word holding register lets back-to-back words stream with no idle cycle between frames. The block sits in front of the receiver in the serial link, and its bit order matches the receiver's.

---
 rtl/serdes_pkg.sv | 23 ++
 rtl/piso_hold_buf.sv | 39 +++
 rtl/parallel_to_serial.sv | 122 ++++++++++++
 tb/tb_parallel_to_serial.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg
// Shared definitions for the serial link transmitter (parallel_to_serial)
// and its matching receiver, so both ends agree on bit-order encoding and
// counter sizing.
//   serdes_state_t : shifter state, IDLE or SHIFT
//   LSB_FIRST_ENC  : LSB_FIRST value that selects bit 0 first
//   MSB_FIRST_ENC  : LSB_FIRST value that selects bit DATA_WIDTH-1 first
//   cnt_width()    : width of a bit counter that spans 0..width-1
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serdes_state_t;

    localparam bit LSB_FIRST_ENC = 1'b1;
    localparam bit MSB_FIRST_ENC = 1'b0;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// piso_hold_buf
// One-word holding register that lets the next word wait while the current
// frame is still being shifted out.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   capture    : store load_data into hold (word accepted while shifting)
//   drain      : hold has been moved into the shifter; mark it empty
//   load_data  : word to capture
//   hold       : held word
//   hold_full  : hold contains a word not yet sent
//   load_ready : !hold_full, driven straight from a flop
module piso_hold_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] hold,
    output logic                  hold_full,
    output logic                  load_ready
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (capture) begin
            hold      <= load_data;
            hold_full <= 1'b1;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

    assign load_ready = !hold_full;

endmodule

// File: rtl/parallel_to_serial.sv
// parallel_to_serial
// Accepts parallel words on a valid/ready handshake and shifts them out one
// bit per clock, marking the first and last bit of each frame. A holding
// register lets consecutive words stream with no idle cycle between frames.
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   load_valid   : word available on load_data
//   load_data    : word to transmit, sampled only at the accept edge
//   load_ready   : block can accept a word this cycle
//   serial_data  : current serial bit (0 when idle)
//   serial_valid : serial_data carries a frame bit
//   frame_start  : first bit of a frame
//   frame_end    : last bit of a frame
//
// state | meaning
// IDLE  | shifter empty, nothing on the serial line
// SHIFT | one frame bit driven per cycle, bit_cnt selects its position
module parallel_to_serial
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = LSB_FIRST_ENC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  serial_data,
    output logic                  serial_valid,
    output logic                  frame_start,
    output logic                  frame_end
);

    localparam int            CW       = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    serdes_state_t         state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt, shreg_shifted;
    logic [DATA_WIDTH-1:0] hold;
    logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                  hold_full;
    logic                  hold_capture;
    logic                  hold_drain;
    logic                  accept;
    logic                  last_bit;

    piso_hold_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .capture    (hold_capture),
        .drain      (hold_drain),
        .load_data  (load_data),
        .hold       (hold),
        .hold_full  (hold_full),
        .load_ready (load_ready)
    );

    assign accept   = load_valid && load_ready;
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);

    assign shreg_shifted = (LSB_FIRST == LSB_FIRST_ENC) ? (shreg >> 1) : (shreg << 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        hold_capture = 1'b0;
        hold_drain   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt   = load_data;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    bit_cnt_nxt = '0;
                    // load_ready is low whenever hold is full, so an accept
                    // cannot coincide with a drain.
                    if (hold_full) begin
                        shreg_nxt  = hold;
                        hold_drain = 1'b1;
                    end else if (accept) begin
                        shreg_nxt = load_data;
                    end else begin
                        shreg_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    shreg_nxt    = shreg_shifted;
                    bit_cnt_nxt  = bit_cnt + CW'(1);
                    hold_capture = accept;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign serial_valid = (state == SHIFT);
    assign serial_data  = serial_valid &&
                          ((LSB_FIRST == LSB_FIRST_ENC) ? shreg[0] : shreg[DATA_WIDTH-1]);
    assign frame_start  = serial_valid && (bit_cnt == '0);
    assign frame_end    = last_bit;

endmodule

// File: tb/tb_parallel_to_serial.sv
module tb_parallel_to_serial;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         rdy [2];
    logic         sd  [2];
    logic         sv  [2];
    logic         fs  [2];
    logic         fe  [2];

    int errors = 0;
    int checks = 0;

    logic [W-1:0] wq [4];
    int           wstart [4];
    logic         lg_v [2][64];
    logic         lg_d [2][64];
    logic         lg_s [2][64];
    logic         lg_e [2][64];
    logic         lg_r [2][64];

    always #5 clk = ~clk;

    // dut index 0: LSB first, index 1: MSB first
    parallel_to_serial #(.DATA_WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy[0]), .serial_data(sd[0]), .serial_valid(sv[0]),
        .frame_start(fs[0]), .frame_end(fe[0]));

    parallel_to_serial #(.DATA_WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy[1]), .serial_data(sd[1]), .serial_valid(sv[1]),
        .frame_start(fs[1]), .frame_end(fe[1]));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Log index c holds outputs sampled at the c-th negedge; a word accepted
    // after negedge c shows its first bit at log index c+1.
    task automatic run_cycles(input int ncyc, input int nwords);
        int widx = 0;
        bit acc;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                lg_v[d][c] = sv[d];
                lg_d[d][c] = sd[d];
                lg_s[d][c] = fs[d];
                lg_e[d][c] = fe[d];
                lg_r[d][c] = rdy[d];
            end
            if (widx < nwords && c >= wstart[widx]) begin
                load_valid = 1'b1;
                load_data  = wq[widx];
            end else begin
                load_valid = 1'b0;
            end
            acc = load_valid && rdy[0];
            @(posedge clk);
            #1;
            if (acc) begin
                load_data = ~load_data;
                widx++;
            end
        end
        load_valid = 1'b0;
    endtask

    // Receiver model: reassemble a word from logged bits starting at s.
    function automatic logic [W-1:0] rebuild(input int d, input int s);
        logic [W-1:0] r = '0;
        for (int k = 0; k < W; k++) begin
            if (d == 0) r[k] = lg_d[d][s+k];
            else        r[W-1-k] = lg_d[d][s+k];
        end
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sv[d], sd[d], fs[d], fe[d], rdy[d]} !== 5'b00001) begin
                errors++;
                $display("FAIL reset_values: dut%0d got v/d/s/e/r=%b%b%b%b%b want 00001",
                         d, sv[d], sd[d], fs[d], fe[d], rdy[d]);
            end
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({sv[d], sd[d], rdy[d]} !== 3'b001) begin
                    errors++;
                    $display("FAIL idle_after_reset: dut%0d got v/d/r=%b%b%b want 001",
                             d, sv[d], sd[d], rdy[d]);
                end
            end
        end
    endtask

    task automatic test_single_word();
        logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic ev, ed;
        wq[0] = 8'hA5; wstart[0] = 0;
        run_cycles(12, 1);
        for (int c = 0; c < 12; c++) begin
            ev = (c >= 1 && c <= 8);
            ed = ev ? exp_bits[c-1] : 1'b0;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({lg_v[d][c], lg_d[d][c], lg_s[d][c], lg_e[d][c]} !==
                    {ev, ed, (c == 1), (c == 8)}) begin
                    errors++;
                    $display("FAIL single_a5: dut%0d cycle %0d got v/d/s/e=%b%b%b%b want %b%b%b%b",
                             d, c, lg_v[d][c], lg_d[d][c], lg_s[d][c], lg_e[d][c],
                             ev, ed, (c == 1), (c == 8));
                end
            end
        end
    endtask

    task automatic test_bit_order();
        // 8'h13 = 0001_0011
        logic exp_lsb [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic exp_msb [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic ed;
        wq[0] = 8'h13; wstart[0] = 0;
        run_cycles(11, 1);
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < 2; d++) begin
                ed = (d == 0) ? exp_lsb[k] : exp_msb[k];
                checks++;
                if (lg_d[d][k+1] !== ed || lg_v[d][k+1] !== 1'b1) begin
                    errors++;
                    $display("FAIL bit_order_13: dut%0d bit %0d got d=%b v=%b want d=%b v=1",
                             d, k, lg_d[d][k+1], lg_v[d][k+1], ed);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic er;
        wq[0] = 8'h01; wq[1] = 8'hFF; wq[2] = 8'h3C;
        wstart[0] = 0; wstart[1] = 0; wstart[2] = 0;
        run_cycles(28, 3);
        for (int c = 0; c < 28; c++) begin
            er = !((c >= 2 && c <= 8) || (c >= 10 && c <= 16));
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({lg_v[d][c], lg_r[d][c], lg_s[d][c], lg_e[d][c]} !==
                    {(c >= 1 && c <= 24), er, (c == 1 || c == 9 || c == 17),
                     (c == 8 || c == 16 || c == 24)}) begin
                    errors++;
                    $display("FAIL stream: dut%0d cycle %0d got v/r/s/e=%b%b%b%b want %b%b%b%b",
                             d, c, lg_v[d][c], lg_r[d][c], lg_s[d][c], lg_e[d][c],
                             (c >= 1 && c <= 24), er, (c == 1 || c == 9 || c == 17),
                             (c == 8 || c == 16 || c == 24));
                end
            end
        end
        for (int f = 0; f < 3; f++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rebuild(d, 1 + 8*f) !== wq[f]) begin
                    errors++;
                    $display("FAIL stream_word: dut%0d frame %0d got %h want %h",
                             d, f, rebuild(d, 1 + 8*f), wq[f]);
                end
            end
        end
    endtask

    task automatic test_last_bit_accept();
        wq[0] = 8'hC3; wq[1] = 8'h5A;
        wstart[0] = 0; wstart[1] = 8;
        run_cycles(20, 2);
        for (int c = 0; c < 20; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({lg_v[d][c], lg_r[d][c], lg_s[d][c], lg_e[d][c]} !==
                    {(c >= 1 && c <= 16), 1'b1, (c == 1 || c == 9), (c == 8 || c == 16)}) begin
                    errors++;
                    $display("FAIL last_bit_accept: dut%0d cycle %0d got v/r/s/e=%b%b%b%b want %b1%b%b",
                             d, c, lg_v[d][c], lg_r[d][c], lg_s[d][c], lg_e[d][c],
                             (c >= 1 && c <= 16), (c == 1 || c == 9), (c == 8 || c == 16));
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rebuild(d, 1) !== 8'hC3 || rebuild(d, 9) !== 8'h5A) begin
                errors++;
                $display("FAIL last_bit_words: dut%0d got %h %h want c3 5a",
                         d, rebuild(d, 1), rebuild(d, 9));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int nvalid;
        wq[0] = 8'hF0; wq[1] = 8'h0F;
        wstart[0] = 0; wstart[1] = 0;
        run_cycles(4, 2);
        // now showing bit 3 of F0, with 0F waiting in hold
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sv[d], rdy[d], sd[d]} !== {1'b1, 1'b0, (d == 1)}) begin
                errors++;
                $display("FAIL pre_abort: dut%0d got v/r/d=%b%b%b want 10%b",
                         d, sv[d], rdy[d], sd[d], (d == 1));
            end
        end
        #2;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sv[d], sd[d], fs[d], fe[d], rdy[d]} !== 5'b00001) begin
                errors++;
                $display("FAIL async_abort: dut%0d got v/d/s/e/r=%b%b%b%b%b want 00001",
                         d, sv[d], sd[d], fs[d], fe[d], rdy[d]);
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({sv[d], sd[d], rdy[d]} !== 3'b001) begin
                    errors++;
                    $display("FAIL no_resume: dut%0d got v/d/r=%b%b%b want 001",
                             d, sv[d], sd[d], rdy[d]);
                end
            end
        end
        wq[0] = 8'h5A; wstart[0] = 0;
        run_cycles(12, 1);
        for (int d = 0; d < 2; d++) begin
            nvalid = 0;
            for (int c = 0; c < 12; c++) nvalid += int'(lg_v[d][c]);
            checks++;
            if (nvalid != 8 || lg_s[d][1] !== 1'b1 || rebuild(d, 1) !== 8'h5A) begin
                errors++;
                $display("FAIL clean_restart: dut%0d got nvalid=%0d start=%b word=%h want 8 1 5a",
                         d, nvalid, lg_s[d][1], rebuild(d, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bit_order();
        test_back_to_back();
        test_last_bit_accept();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
